// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack and hands words to decode.
// Define FETCH_PERF_EN to add the stall_cnt_o performance counter (and its CNT_W parameter).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_instr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc4_o,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_idx_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        misalign_o
`ifdef FETCH_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] kill_addr_q;

    logic [31:0] flush_tgt;
    logic [31:0] br_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] redir_tgt;

    assign flush_tgt = {flush_pc_i[31:2], 2'b00};
    assign br_tgt    = id_pc4_o + {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
    assign jump_tgt  = {id_pc4_o[31:28], jump_idx_i, 2'b00};
    assign jr_tgt    = {jr_addr_i[31:2], 2'b00};

    always_comb begin
        redir_tgt = pc_q;
        if (jr_i) begin
            redir_tgt = jr_tgt;
        end else if (jump_i) begin
            redir_tgt = jump_tgt;
        end else if (br_taken_i) begin
            redir_tgt = br_tgt;
        end
    end

    // KILL keeps presenting the abandoned address until memory retires it.
    assign imem_addr_o = (state_q == KILL) ? kill_addr_q : pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            imem_req_o  <= 1'b0;
            id_valid_o  <= 1'b0;
            id_instr_o  <= '0;
            id_pc4_o    <= '0;
            misalign_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (flush_i) begin
                pc_q       <= flush_tgt;
                id_valid_o <= 1'b0;
                imem_req_o <= 1'b1;
                misalign_o <= |flush_pc_i[1:0];
                case (state_q)
                    FETCH: begin
                        if (!imem_ack_i) begin
                            kill_addr_q <= pc_q;
                            state_q     <= KILL;
                        end
                    end
                    KILL: begin
                        if (imem_ack_i) begin
                            state_q <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= FETCH;
                        imem_req_o <= 1'b1;
                    end
                    FETCH: begin
                        if (imem_ack_i) begin
                            id_instr_o <= imem_instr_i;
                            id_pc4_o   <= pc_q + 32'd4;
                            pc_q       <= pc_q + 32'd4;
                            id_valid_o <= 1'b1;
                            imem_req_o <= 1'b0;
                            state_q    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (id_ready_i) begin
                            pc_q       <= redir_tgt;
                            misalign_o <= jr_i & (|jr_addr_i[1:0]);
                            id_valid_o <= 1'b0;
                            imem_req_o <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                    KILL: begin
                        if (imem_ack_i) begin
                            state_q <= FETCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (((imem_req_o & ~imem_ack_i) | (id_valid_o & ~id_ready_i))
                     && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: redirect vector table plus flush/hold/reset sequences,
// with a memory model feeding a scoreboard of expected decode-side words.
module tb_fetch_pc_unit;
    localparam int unsigned CNT_W = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc4_o;
    logic        br_taken_i;
    logic [15:0] br_imm_i;
    logic        jump_i;
    logic [25:0] jump_idx_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        misalign_o;
`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] stall_exp;
`endif

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000)
`ifdef FETCH_PERF_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_instr_i(imem_instr_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_instr_o(id_instr_o), .id_pc4_o(id_pc4_o),
        .br_taken_i(br_taken_i), .br_imm_i(br_imm_i),
        .jump_i(jump_i), .jump_idx_i(jump_idx_i),
        .jr_i(jr_i), .jr_addr_i(jr_addr_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .misalign_o(misalign_o)
`ifdef FETCH_PERF_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jra;
        logic [31:0] exp_pc4;
        logic [31:0] exp_next;
        logic        exp_mis;
        int unsigned delay;
    } vec_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned ack_delay = 0;
    int unsigned mem_wait = 0;
    bit          kill_pending = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(logic br, logic [15:0] imm, logic jmp, logic [25:0] idx,
                                logic jr, logic [31:0] jra, logic [31:0] pc4,
                                logic [31:0] nxt, logic mis, int unsigned dly);
        vec_t v;
        v.br = br; v.imm = imm; v.jmp = jmp; v.idx = idx; v.jr = jr; v.jra = jra;
        v.exp_pc4 = pc4; v.exp_next = nxt; v.exp_mis = mis; v.delay = dly;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the memory model; called at posedge+1 with the other inputs already driven.
    task automatic step();
        logic ack;
        ack = 1'b0;
        if (imem_req_o) begin
            if (prev_wait) chk("addr_stable", imem_addr_o, prev_addr);
            if (mem_wait >= ack_delay) begin
                ack = 1'b1;
                mem_wait = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
        imem_ack_i   = ack;
        imem_instr_i = ack ? word_of(imem_addr_o) : $urandom;
        if (flush_i) exp_q.delete();
        if (ack) begin
            if (!kill_pending && !flush_i)
                exp_q.push_back('{instr: word_of(imem_addr_o), pc4: imem_addr_o + 32'd4});
            kill_pending = 1'b0;
        end else if (flush_i && imem_req_o) begin
            kill_pending = 1'b1;
        end
`ifdef FETCH_PERF_EN
        if (((imem_req_o && !ack) || (id_valid_o && !id_ready_i)) && stall_exp != '1)
            stall_exp++;
`endif
        prev_wait = imem_req_o && !ack;
        prev_addr = imem_addr_o;
        @(posedge clk_i);
        #1;
        imem_ack_i = 1'b0;
    endtask

    task automatic consume(input vec_t v);
        int unsigned n;
        exp_t e;
        n = 0;
        while (!id_valid_o && n < 30) begin
            step();
            n++;
        end
        chk("valid_seen", 32'(id_valid_o), 32'd1);
        if (id_valid_o) begin
            chk("pc4_table", id_pc4_o, v.exp_pc4);
            chk("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", id_instr_o, e.instr);
                chk("sb_pc4", id_pc4_o, e.pc4);
            end
        end
        ack_delay  = v.delay;
        id_ready_i = 1'b1;
        br_taken_i = v.br; br_imm_i = v.imm; jump_i = v.jmp; jump_idx_i = v.idx;
        jr_i = v.jr; jr_addr_i = v.jra;
        step();
        id_ready_i = 1'b0; br_taken_i = 1'b0; br_imm_i = '0; jump_i = 1'b0;
        jump_idx_i = '0; jr_i = 1'b0; jr_addr_i = '0;
        chk("misalign", 32'(misalign_o), 32'(v.exp_mis));
        chk("valid_drop", 32'(id_valid_o), 32'd0);
        chk("req_after", 32'(imem_req_o), 32'd1);
        chk("next_addr", imem_addr_o, v.exp_next);
        step();
        chk("misalign_end", 32'(misalign_o), 32'd0);
`ifdef FETCH_PERF_EN
        chk("stall_cnt", 32'(stall_cnt_o), 32'(stall_exp));
`endif
    endtask

    task automatic chk_reset_values();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_instr", id_instr_o, 32'h0);
        chk("rst_pc4", id_pc4_o, 32'h0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_stall", 32'(stall_cnt_o), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        int unsigned n;
`ifdef FETCH_PERF_EN
        logic [CNT_W-1:0] s0;
        stall_exp = '0;
`endif
        //            br  imm       jmp idx           jr  jra            pc4            next           mis dly
        vecs[0]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0004, 32'h0000_0004, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0008, 32'h0000_0008, 0, 0);
        vecs[2]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_000C, 32'h0000_000C, 0, 1);
        vecs[3]  = mk(1, 16'hFFFC, 0, 26'h0,       0, 32'h0,        32'h0000_0010, 32'h0000_0000, 0, 0);
        vecs[4]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0004, 32'h0000_0004, 0, 2);
        vecs[5]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0008, 32'h0000_0008, 0, 0);
        vecs[6]  = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_000C, 32'h0000_000C, 0, 0);
        vecs[7]  = mk(1, 16'h0007, 1, 26'h0000040, 0, 32'h0,        32'h0000_0010, 32'h0000_0100, 0, 1);
        vecs[8]  = mk(1, 16'h0001, 1, 26'h0000003, 1, 32'h0000_0103, 32'h0000_0104, 32'h0000_0100, 1, 0);
        vecs[9]  = mk(1, 16'h0003, 0, 26'h0,       0, 32'h0,        32'h0000_0104, 32'h0000_0110, 0, 0);
        vecs[10] = mk(0, 16'h0000, 0, 26'h0,       1, 32'h0000_0200, 32'h0000_0114, 32'h0000_0200, 0, 0);
        vecs[11] = mk(0, 16'h0000, 1, 26'h3FFFFFF, 0, 32'h0,        32'h0000_0204, 32'h0FFF_FFFC, 0, 0);
        vecs[12] = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h1000_0000, 32'h1000_0000, 0, 0);
        vecs[13] = mk(1, 16'h8000, 0, 26'h0,       0, 32'h0,        32'h1000_0004, 32'h0FFE_0004, 0, 0);
        vecs[14] = mk(0, 16'h0000, 0, 26'h0,       1, 32'hFFFF_FFFE, 32'h0FFE_0008, 32'hFFFF_FFFC, 1, 0);
        vecs[15] = mk(0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0000, 32'h0000_0000, 0, 3);

        rst_i = 1'b1; imem_ack_i = 1'b0; imem_instr_i = '0; id_ready_i = 1'b0;
        br_taken_i = 1'b0; br_imm_i = '0; jump_i = 1'b0; jump_idx_i = '0;
        jr_i = 1'b0; jr_addr_i = '0; flush_i = 1'b0; flush_pc_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_values();
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) consume(vecs[i]);

        // Flush while a request is outstanding: old address held, its word discarded.
        flush_i = 1'b1; flush_pc_i = 32'h0000_0200;
        step();
        flush_i = 1'b0;
        chk("kill_req", 32'(imem_req_o), 32'd1);
        chk("kill_addr", imem_addr_o, 32'h0000_0000);
        n = 0;
        while (imem_addr_o != 32'h0000_0200 && n < 10) begin
            chk("kill_valid", 32'(id_valid_o), 32'd0);
            step();
            n++;
        end
        chk("post_kill_addr", imem_addr_o, 32'h0000_0200);
        chk("post_kill_valid", 32'(id_valid_o), 32'd0);
        chk("post_kill_sb", 32'(exp_q.size()), 32'd0);
        consume(mk(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0204, 32'h0000_0204, 0, 2));

        // Flush in the same cycle as the ack: word dropped, refetch at the target.
        ack_delay = 1;
        flush_i = 1'b1; flush_pc_i = 32'h0000_0400;
        step();
        flush_i = 1'b0;
        chk("flush_ack_req", 32'(imem_req_o), 32'd1);
        chk("flush_ack_addr", imem_addr_o, 32'h0000_0400);
        chk("flush_ack_valid", 32'(id_valid_o), 32'd0);
        consume(mk(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0404, 32'h0000_0404, 0, 0));

        // Misaligned flush in HOLD wins over a same-cycle jump.
        chk("hold_before_flush", 32'(id_valid_o), 32'd1);
        flush_i = 1'b1; flush_pc_i = 32'h0000_0301;
        id_ready_i = 1'b1; jump_i = 1'b1; jump_idx_i = 26'h0000040;
        step();
        flush_i = 1'b0; id_ready_i = 1'b0; jump_i = 1'b0; jump_idx_i = '0;
        chk("flush_hold_valid", 32'(id_valid_o), 32'd0);
        chk("flush_hold_addr", imem_addr_o, 32'h0000_0300);
        chk("flush_mis", 32'(misalign_o), 32'd1);
        step();
        chk("flush_mis_end", 32'(misalign_o), 32'd0);
        consume(mk(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0304, 32'h0000_0304, 0, 0));

        // Decode stalls 5 cycles; jr presented without ready must be ignored.
`ifdef FETCH_PERF_EN
        s0 = stall_exp;
`endif
        for (int k = 0; k < 5; k++) begin
            jr_i = 1'b1; jr_addr_i = 32'h0000_0777;
            step();
            chk("hold_instr", id_instr_o, word_of(32'h0000_0304));
            chk("hold_pc4", id_pc4_o, 32'h0000_0308);
            chk("hold_req", 32'(imem_req_o), 32'd0);
            chk("hold_valid", 32'(id_valid_o), 32'd1);
            chk("hold_mis", 32'(misalign_o), 32'd0);
        end
        jr_i = 1'b0; jr_addr_i = '0;
`ifdef FETCH_PERF_EN
        chk("stall_plus5", 32'(stall_cnt_o), 32'(CNT_W'(s0 + CNT_W'(5))));
`endif
        consume(mk(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0308, 32'h0000_0308, 0, 4));

        // Reset in the middle of an outstanding fetch.
        chk("pre_rst_req", 32'(imem_req_o), 32'd1);
        rst_i = 1'b1;
        #2;
        chk_reset_values();
        imem_ack_i = 1'b1; imem_instr_i = 32'hBAD0_BAD0;
        @(posedge clk_i);
        #1;
        imem_ack_i = 1'b0;
        chk_reset_values();
        rst_i = 1'b0;
        exp_q.delete();
        kill_pending = 1'b0; prev_wait = 1'b0; mem_wait = 0; ack_delay = 0;
`ifdef FETCH_PERF_EN
        stall_exp = '0;
`endif
        consume(mk(0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0004, 32'h0000_0004, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
